// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the single-cycle core and a
// host port (loader / debug).
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   -> round-robin between core and host, using a 1-bit
//                last-winner register
//   undefined -> fixed core priority, with a host starvation guard
//                (HOST_MAX_WAIT)
//
// Ports
//   clock, reset         rising-edge clock; asynchronous active-low reset
//   cpu_daddr/dread/dwrite/dwdata
//                        core data request
//   cpu_ddata            read data to the core (bypassed in the completion cycle)
//   cpu_stall            core must hold its PC and state this cycle
//   host_req/we/addr/wdata
//                        host request, held stable until host_gnt
//   host_gnt             pulse: the host request issued this cycle
//   host_rvalid          pulse: host_rdata carries fresh read data
//   host_rdata           last host read data (bypassed in the completion cycle)
//   mem_addr/re/we/wdata/rdata
//                        memory side; read data is valid LAT cycles after mem_re
module dmem_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int LAT           = 2,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] cpu_daddr,
  input  logic          cpu_dread,
  input  logic          cpu_dwrite,
  input  logic [DW-1:0] cpu_dwdata,
  output logic [DW-1:0] cpu_ddata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, CPU_RD, HOST_RD} state_t;

  state_t        state, state_nx;
  logic [2:0]    cnt, cnt_nx;          // cycles spent in the read wait state, 1..LAT
  logic [DW-1:0] cpu_ddata_q, host_rdata_q;
  logic          core_req, host_win, done;

  assign core_req = cpu_dread | cpu_dwrite;
  // Completion is the LAT-th cycle after the issue cycle.
  assign done     = (state != IDLE) && (cnt == 3'(LAT));

`ifdef DMEM_ARB_RR_EN
  logic last_host;  // 1: host won the most recent contested or uncontested issue

  assign host_win = host_req && (!core_req || !last_host);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_host <= 1'b1;  // "host last" so the core wins the first collision
    end else if (state == IDLE && (core_req || host_req)) begin
      last_host <= host_win;
    end
  end
`else
  localparam int SW = $clog2(HOST_MAX_WAIT + 1);
  logic [SW-1:0] starv;

  assign host_win = host_req && (!core_req || starv == SW'(HOST_MAX_WAIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starv <= '0;
    end else if (!host_req || host_gnt) begin
      starv <= '0;
    end else if (starv != SW'(HOST_MAX_WAIT)) begin
      starv <= starv + SW'(1);
    end
  end
`endif

  // NOTE: every output of this block gets a default before the case so that no
  // path leaves a signal unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    mem_addr    = cpu_daddr;
    mem_wdata   = cpu_dwdata;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    cpu_stall   = 1'b0;
    cpu_ddata   = cpu_ddata_q;
    host_rdata  = host_rdata_q;
    // While reset is asserted, the strobes and the stall stay quiet even if
    // requests are already present.
    if (reset) begin
      case (state)
        IDLE: begin
          if (host_win) begin
            host_gnt  = 1'b1;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            cpu_stall = core_req;
            if (host_we) begin
              mem_we = 1'b1;
            end else begin
              mem_re   = 1'b1;
              state_nx = HOST_RD;
              cnt_nx   = 3'd1;
            end
          end else if (core_req) begin
            // If read and write are both requested, the access is a write.
            if (cpu_dwrite) begin
              mem_we = 1'b1;
            end else begin
              mem_re    = 1'b1;
              cpu_stall = 1'b1;
              state_nx  = CPU_RD;
              cnt_nx    = 3'd1;
            end
          end
        end
        CPU_RD: begin
          if (done) begin
            cpu_ddata = mem_rdata;
            state_nx  = IDLE;
          end else begin
            cpu_stall = 1'b1;
            cnt_nx    = cnt + 3'd1;
          end
        end
        HOST_RD: begin
          cpu_stall = core_req;
          if (done) begin
            host_rvalid = 1'b1;
            host_rdata  = mem_rdata;
            state_nx    = IDLE;
          end else begin
            cnt_nx = cnt + 3'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cpu_ddata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == CPU_RD && done) cpu_ddata_q <= mem_rdata;
      if (state == HOST_RD && done) host_rdata_q <= mem_rdata;
    end
  end

endmodule
